// File: rtl/seq_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// seq_packer: framed byte stream -> {ID, LENGTH, TARGET} feed words. Rev 1.0
// Define SEQ_PACKER_DROP_BAD_EN to drop records with bad chars or overflow.
//------------------------------------------------------------------------------
module seq_packer #(
  parameter int TARGET_LENGTH = 128,
  parameter int LEN_WIDTH     = 12,
  parameter int ID_WIDTH      = 48,
  parameter int OUT_WIDTH     = ID_WIDTH + LEN_WIDTH + 2*TARGET_LENGTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic                 in_eop,
  output logic                 in_ready,
  input  logic                 full,
  output logic                 ld,
  output logic [OUT_WIDTH-1:0] feed_out,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int ID_BYTES = ID_WIDTH / 8;
  localparam int CNT_W    = $clog2(ID_BYTES + 1);
  localparam int TGT_W    = 2 * TARGET_LENGTH;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX  = LEN_WIDTH'(TARGET_LENGTH);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ID_BYTES - 1);
  localparam logic [1:0] ERR_BAD = 2'b01;
  localparam logic [1:0] ERR_OVF = 2'b10;
  localparam logic [1:0] ERR_FRM = 2'b11;

  typedef enum logic [1:0] {IDLE, HDR, BODY, HOLD} state_t;

  state_t               state_q, state_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [TGT_W-1:0]     tgt_q, tgt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 bad_q, bad_d;
  logic                 ovf_q, ovf_d;
  logic                 slot_vld_q, slot_vld_d;
  logic                 slot_rdy_q, slot_rdy_d;
  logic [OUT_WIDTH-1:0] slot_q, slot_d;

  logic       accept;
  logic       load_slot;
  logic       drop_rec;
  logic       base_bad;
  logic [1:0] base_code;

  // The slot is held back one cycle after loading so ld lands no earlier than eop+2.
  assign ld       = slot_rdy_q && !full && !rst;
  assign feed_out = slot_q;

  // Case fold by forcing bit 5; only 'A'/'a' etc. land on the lower-case codes.
  always_comb begin
    base_code = 2'b00;
    base_bad  = 1'b0;
    case (in_data | 8'h20)
      8'h61:   base_code = 2'b00;
      8'h63:   base_code = 2'b01;
      8'h67:   base_code = 2'b10;
      8'h74:   base_code = 2'b11;
      default: base_bad  = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    bad_d     = bad_q;
    ovf_d     = ovf_q;
    slot_d    = slot_q;
    load_slot = 1'b0;
    drop_rec  = 1'b0;
    err       = 1'b0;
    err_code  = 2'b00;
    in_ready  = !rst && (state_q != HOLD);
    accept    = in_valid && in_ready;

    if (accept && in_sop) begin
      if ((state_q != IDLE) || in_eop) begin
        err      = 1'b1;
        err_code = ERR_FRM;
      end
      id_d  = ID_WIDTH'(in_data);
      cnt_d = CNT_W'(1);
      len_d = '0;
      tgt_d = '0;
      bad_d = 1'b0;
      ovf_d = 1'b0;
      if (in_eop)
        state_d = IDLE;
      else
        state_d = (ID_BYTES == 1) ? BODY : HDR;
    end else if (accept) begin
      case (state_q)
        HDR: begin
          if (in_eop) begin
            err      = 1'b1;
            err_code = ERR_FRM;
            state_d  = IDLE;
          end else begin
            id_d  = (id_q << 8) | ID_WIDTH'(in_data);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST)
              state_d = BODY;
          end
        end
        BODY: begin
          if (len_q == LEN_MAX) begin
            ovf_d = 1'b1;
          end else begin
            for (int i = 0; i < TARGET_LENGTH; i++)
              if (len_q == LEN_WIDTH'(i))
                tgt_d[2*i +: 2] = base_code;
            len_d = len_q + 1'b1;
          end
          if (base_bad)
            bad_d = 1'b1;
          if (in_eop) begin
            if (ovf_d) begin
              err      = 1'b1;
              err_code = ERR_OVF;
            end else if (bad_d) begin
              err      = 1'b1;
              err_code = ERR_BAD;
            end
`ifdef SEQ_PACKER_DROP_BAD_EN
            drop_rec = ovf_d || bad_d;
`endif
            if (drop_rec) begin
              state_d = IDLE;
            end else if (slot_vld_q) begin
              state_d = HOLD;
            end else begin
              load_slot = 1'b1;
              slot_d    = {id_q, len_d, tgt_d};
              state_d   = IDLE;
            end
          end
        end
        default: begin
          err      = 1'b1;
          err_code = ERR_FRM;
        end
      endcase
    end else if ((state_q == HOLD) && (!slot_vld_q || ld)) begin
      // Overwriting during the ld cycle is safe: the feeder captures on ld.
      load_slot = 1'b1;
      slot_d    = {id_q, len_q, tgt_q};
      state_d   = IDLE;
    end

    slot_vld_d = slot_vld_q;
    slot_rdy_d = slot_rdy_q;
    if (load_slot) begin
      slot_vld_d = 1'b1;
      slot_rdy_d = 1'b0;
    end else if (ld) begin
      slot_vld_d = 1'b0;
      slot_rdy_d = 1'b0;
    end else begin
      slot_rdy_d = slot_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      len_q      <= '0;
      tgt_q      <= '0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      ovf_q      <= 1'b0;
      slot_vld_q <= 1'b0;
      slot_rdy_q <= 1'b0;
      slot_q     <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      len_q      <= len_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      ovf_q      <= ovf_d;
      slot_vld_q <= slot_vld_d;
      slot_rdy_q <= slot_rdy_d;
      slot_q     <= slot_d;
    end
  end

endmodule
`default_nettype wire
